cp0_exc_ctrl: RTL and testbench
===============================

// Module: cp0_exc_ctrl
// PURPOSE
//  Parametrised coprocessor-0 for the single-cycle MIPS core.
//  Holds Status/Cause/EPC (plus optional Count/Compare) and serves mfc0/mtc0.
//  Arbitrates synchronous exceptions, masked external interrupts and eret.
//  Drives the redirect PC into the fetch mux.
// PARAMETERS
//  NUM_IRQ      6             external interrupt lines, 1..6, mapped to Cause.IP[2+:NUM_IRQ]
//  EXC_VECTOR   32'h00400004  handler entry PC for every exception and interrupt
//  STATUS_RST   32'h0000FF01  Status reset value (IM all 1, IE=1, EXL=0)
// PORTS
//  clk          in   1        core clock; all state updates on posedge
//  rst_n        in   1        synchronous active-low reset
//  mfc0         in   1        read request; rdata valid same cycle
//  mtc0         in   1        write request; reg[addr] <= wdata at next posedge
//  addr         in   5        CP0 register index
//  wdata        in   32       mtc0 data (rt)
//  pc           in   32       PC of instruction in execute
//  exc_valid    in   1        synchronous exception raised by current instruction
//  exc_code     in   5        ExcCode for exc_valid (8 Sys, 9 Bp, 10 RI, 12 Ov)
//  eret         in   1        eret executing this cycle
//  irq          in   NUM_IRQ  level-sensitive external interrupts, already synchronous to clk
//  rdata        out  32       mfc0 result; 0 when mfc0=0 or index unimplemented
//  redirect     out  1        fetch must take redirect_pc instead of pc+4
//  redirect_pc  out  32       EXC_VECTOR on exception/interrupt; EPC on eret
//  status       out  32       current Status register
// BEHAVIOUR
//  Regs: 12 Status {IM[15:8], EXL[1], IE[0]}; 13 Cause {IP[15:8], ExcCode[6:2]}; 14 EPC.
//  Other Status/Cause bits read 0, writes ignored. Cause.IP[1:0] software-writable only.
//  Reset (rst_n=0 at posedge): Status=STATUS_RST, Cause=0, EPC=0, Count/Compare=0.
//  During reset: redirect=0, redirect_pc=0, rdata=0.
//  Cause.IP[2+i] <= irq[i] every cycle (level follows line, not sticky).
//  int_take = IE & ~EXL & |(IP & IM), evaluated combinationally on current register values.
//  Priority per cycle: exc_valid > int_take > eret > mtc0.
//    exc_valid: EPC<=pc; ExcCode<=exc_code; EXL<=1; redirect=1; redirect_pc=EXC_VECTOR.
//    int_take: EPC<=pc (instruction not committed); ExcCode<=0; EXL<=1; redirect to EXC_VECTOR.
//    eret (no exc/int): EXL<=0; redirect=1; redirect_pc=EPC (current value).
//    mtc0: write lands only if no higher-priority event; dropped otherwise.
//  exc_valid while EXL=1: EPC is NOT overwritten; ExcCode updated; redirect still asserted.
//  eret with EXL=0: EXL stays 0, redirect to EPC anyway (software error, not trapped).
//  mtc0 to Status that sets IE with pending IP: interrupt taken next cycle, not same cycle.
//  mfc0 and mtc0 to same reg in one cycle: rdata returns old value.
//  Latency: redirect/rdata combinational; register effects visible the cycle after.
// CONFIGURATION
//  CP0_TIMER_EN defined:
//    reg 9 Count increments every cycle, wraps 2^32-1 -> 0.
//    reg 11 Compare; Count==Compare sets sticky Cause.IP7.
//    mtc0 to Compare clears IP7; mtc0 to Count loads value (no increment that cycle).
//  CP0_TIMER_EN undefined:
//    regs 9/11 read 0, writes ignored; IP7 driven from irq[5] if NUM_IRQ==6, else 0.
// STRUCTURE
//  Package cp0_pkg:
//    register indices (CP0_COUNT=9, CP0_COMPARE=11, CP0_STATUS=12, CP0_CAUSE=13, CP0_EPC=14)
//    ExcCode constants (EXC_INT=0, EXC_SYS=8, EXC_BP=9, EXC_RI=10, EXC_OV=12)
//    Status/Cause bit-position localparams
//  Sub-module cp0_timer (Count/Compare/IP7 logic), instantiated only under CP0_TIMER_EN.
// TESTING
//  1 Reset: rst_n=0 one cycle -> status=32'h0000FF01, mfc0 12/13/14 read FF01/0/0, redirect=0.
//  2 Syscall: exc_valid=1, exc_code=8, pc=0x00400100
//    -> redirect_pc=0x00400004; next cycle EPC=0x00400100, Cause=0x20, Status.EXL=1.
//  3 eret after test 2 -> redirect_pc=0x00400100; next cycle Status.EXL=0.
//  4 Interrupt masking:
//    IM=0, irq[0]=1 -> no redirect, Cause.IP2=1.
//    mtc0 Status=0x401 -> taken next cycle, ExcCode=0.
//    exc_valid same cycle as int -> ExcCode=exc_code.
//  5 Nested: exc_valid while EXL=1 with pc=0x200 -> EPC unchanged, ExcCode updated.
//    mtc0 in exception cycle -> write dropped.
//  6 CP0_TIMER_EN: Count=0, Compare=5 -> IP7 set after 5 cycles, sticky; mtc0 Compare clears.
//    Count=0xFFFFFFFF wraps to 0.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared constants for the coprocessor-0 exception controller.
// Contents: CP0 register indices, ExcCode values, Status/Cause bit positions
// and a helper that assembles the architectural Status word.
package cp0_pkg;

    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_STATUS  = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;

    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_SYS = 5'd8;
    localparam logic [4:0] EXC_BP  = 5'd9;
    localparam logic [4:0] EXC_RI  = 5'd10;
    localparam logic [4:0] EXC_OV  = 5'd12;

    localparam int ST_IE      = 0;
    localparam int ST_EXL     = 1;
    localparam int ST_IM_LSB  = 8;
    localparam int CA_EXC_LSB = 2;
    localparam int CA_IP_LSB  = 8;
    localparam int IP_TIMER   = 7;

    function automatic logic [31:0] status_word(input logic [7:0] im,
                                                input logic       exl,
                                                input logic       ie);
        logic [31:0] w;
        w             = '0;
        w[ST_IM_LSB+:8] = im;
        w[ST_EXL]     = exl;
        w[ST_IE]      = ie;
        return w;
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer for CP0.
// Ports: clk, rst_n (sync, active low), count_we_i/compare_we_i (write
// strobes, already priority-qualified by the caller), wdata_i, count_o,
// compare_o, ip7_o (sticky timer interrupt pending).
module cp0_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        count_we_i,
    input  logic        compare_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        ip7_o
);

    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        ip7_q, ip7_d;

    always_comb begin
        count_d   = count_we_i ? wdata_i : count_q + 32'd1;
        compare_d = compare_we_i ? wdata_i : compare_q;
        // A Compare write acknowledges the interrupt and wins over a match.
        ip7_d     = compare_we_i ? 1'b0 : (ip7_q | (count_q == compare_q));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q   <= '0;
            compare_q <= '0;
            ip7_q     <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            ip7_q     <= ip7_d;
        end
    end

    assign count_o   = count_q;
    assign compare_o = compare_q;
    assign ip7_o     = ip7_q;

endmodule

// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 for the single-cycle MIPS core: Status/Cause/EPC, mfc0/mtc0,
// exception/interrupt/eret arbitration and the fetch redirect.
// Optional macro CP0_TIMER_EN adds Count (9) / Compare (11) and the sticky
// timer interrupt on Cause.IP7 (it then replaces irq[5] on IP7).
// Ports: clk, rst_n (sync, active low), mfc0/mtc0/addr/wdata (register
// access), pc, exc_valid/exc_code, eret, irq[NUM_IRQ], rdata, redirect,
// redirect_pc, status.
module cp0_exc_ctrl
    import cp0_pkg::*;
#(
    parameter int          NUM_IRQ    = 6,
    parameter logic [31:0] EXC_VECTOR = 32'h00400004,
    parameter logic [31:0] STATUS_RST = 32'h0000FF01
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mfc0,
    input  logic               mtc0,
    input  logic [4:0]         addr,
    input  logic [31:0]        wdata,
    input  logic [31:0]        pc,
    input  logic               exc_valid,
    input  logic [4:0]         exc_code,
    input  logic               eret,
    input  logic [NUM_IRQ-1:0] irq,
    output logic [31:0]        rdata,
    output logic               redirect,
    output logic [31:0]        redirect_pc,
    output logic [31:0]        status
);

    logic [7:0]         im_q, im_d;
    logic               exl_q, exl_d;
    logic               ie_q, ie_d;
    logic [1:0]         ip_sw_q, ip_sw_d;
    logic [4:0]         exc_code_q, exc_code_d;
    logic [31:0]        epc_q, epc_d;
    logic [NUM_IRQ-1:0] irq_q;

    logic [7:0]  ip;
    logic        int_take;
    logic [31:0] cause_w;

`ifdef CP0_TIMER_EN
    logic        count_we, compare_we;
    logic [31:0] count_w, compare_w;
    logic        timer_ip7;

    cp0_timer u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .count_we_i   (count_we),
        .compare_we_i (compare_we),
        .wdata_i      (wdata),
        .count_o      (count_w),
        .compare_o    (compare_w),
        .ip7_o        (timer_ip7)
    );
`endif

    always_comb begin
        ip = {6'b0, ip_sw_q};
        for (int i = 0; i < NUM_IRQ; i++) ip[2+i] = irq_q[i];
`ifdef CP0_TIMER_EN
        ip[IP_TIMER] = timer_ip7;
`endif
    end

    assign int_take = ie_q & ~exl_q & (|(ip & im_q));

    always_comb begin
        cause_w                   = '0;
        cause_w[CA_IP_LSB+:8]     = ip;
        cause_w[CA_EXC_LSB+:5]    = exc_code_q;
    end

    always_comb begin
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        ip_sw_d    = ip_sw_q;
        exc_code_d = exc_code_q;
        epc_d      = epc_q;
`ifdef CP0_TIMER_EN
        count_we   = 1'b0;
        compare_we = 1'b0;
`endif
        if (exc_valid) begin
            // A nested exception keeps the original return address.
            if (!exl_q) epc_d = pc;
            exc_code_d = exc_code;
            exl_d      = 1'b1;
        end else if (int_take) begin
            epc_d      = pc;
            exc_code_d = EXC_INT;
            exl_d      = 1'b1;
        end else if (eret) begin
            exl_d = 1'b0;
        end else if (mtc0) begin
            case (addr)
                CP0_STATUS: begin
                    im_d  = wdata[ST_IM_LSB+:8];
                    exl_d = wdata[ST_EXL];
                    ie_d  = wdata[ST_IE];
                end
                CP0_CAUSE: ip_sw_d = wdata[CA_IP_LSB+:2];
                CP0_EPC:   epc_d   = wdata;
`ifdef CP0_TIMER_EN
                CP0_COUNT:   count_we   = 1'b1;
                CP0_COMPARE: compare_we = 1'b1;
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            im_q       <= STATUS_RST[ST_IM_LSB+:8];
            exl_q      <= STATUS_RST[ST_EXL];
            ie_q       <= STATUS_RST[ST_IE];
            ip_sw_q    <= '0;
            exc_code_q <= '0;
            epc_q      <= '0;
            irq_q      <= '0;
        end else begin
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            ip_sw_q    <= ip_sw_d;
            exc_code_q <= exc_code_d;
            epc_q      <= epc_d;
            irq_q      <= irq;
        end
    end

    assign status   = status_word(im_q, exl_q, ie_q);
    assign redirect = rst_n & (exc_valid | int_take | eret);

    always_comb begin
        redirect_pc = '0;
        if (rst_n) begin
            if (exc_valid || int_take) redirect_pc = EXC_VECTOR;
            else if (eret)             redirect_pc = epc_q;
        end
    end

    always_comb begin
        rdata = '0;
        if (rst_n && mfc0) begin
            case (addr)
                CP0_STATUS:  rdata = status;
                CP0_CAUSE:   rdata = cause_w;
                CP0_EPC:     rdata = epc_q;
`ifdef CP0_TIMER_EN
                CP0_COUNT:   rdata = count_w;
                CP0_COMPARE: rdata = compare_w;
`endif
                default:     rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
module tb_cp0_exc_ctrl;

    localparam int          NUM_IRQ = 6;
    localparam logic [31:0] VEC     = 32'h00400004;
    localparam logic [31:0] ST_RST  = 32'h0000FF01;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               mfc0 = 1'b0, mtc0 = 1'b0, exc_valid = 1'b0, eret = 1'b0;
    logic [4:0]         addr = '0, exc_code = '0;
    logic [31:0]        wdata = '0, pc = '0;
    logic [NUM_IRQ-1:0] irq = '0;
    logic [31:0]        rdata, redirect_pc, status;
    logic               redirect;

    cp0_exc_ctrl dut (
        .clk(clk), .rst_n(rst_n), .mfc0(mfc0), .mtc0(mtc0), .addr(addr),
        .wdata(wdata), .pc(pc), .exc_valid(exc_valid), .exc_code(exc_code),
        .eret(eret), .irq(irq), .rdata(rdata), .redirect(redirect),
        .redirect_pc(redirect_pc), .status(status)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic [31:0] rpc;
        logic [31:0] status;
        logic        redirect;
        logic        chk_status;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: architectural register words.
    logic [31:0] m_status, m_cause, m_epc, m_count, m_compare;
    logic        m_ip7, m_init = 1'b0;
    logic [5:0]  cur_irq = '0;

    function automatic logic [31:0] eff_cause();
        logic [31:0] c;
        c = m_cause;
`ifdef CP0_TIMER_EN
        c[15] = m_ip7;
`endif
        return c;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        case (a)
            5'd12: return m_status;
            5'd13: return eff_cause();
            5'd14: return m_epc;
`ifdef CP0_TIMER_EN
            5'd9:  return m_count;
            5'd11: return m_compare;
`endif
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic rst, input logic mf, input logic mt,
                       input logic [4:0] a, input logic [31:0] wd, input logic [31:0] pcv,
                       input logic ev, input logic [4:0] ec, input logic er);
        exp_t        e;
        logic [31:0] c;
        logic        it, lands;
        @(negedge clk);
        #1;
        rst_n = ~rst; mfc0 = mf; mtc0 = mt; addr = a; wdata = wd; pc = pcv;
        exc_valid = ev; exc_code = ec; eret = er; irq = cur_irq;

        c  = eff_cause();
        it = m_init && m_status[0] && !m_status[1] && ((c[15:8] & m_status[15:8]) != 8'h0);
        e.status     = m_status;
        e.chk_status = m_init;
        if (rst) begin
            e.redirect = 1'b0; e.rpc = 32'h0; e.rdata = 32'h0;
        end else begin
            e.redirect = ev | it | er;
            e.rpc      = (ev | it) ? VEC : (er ? m_epc : 32'h0);
            e.rdata    = mf ? model_read(a) : 32'h0;
        end
        q.push_back(e);

        if (rst) begin
            m_status = ST_RST; m_cause = 0; m_epc = 0;
            m_count = 0; m_compare = 0; m_ip7 = 0; m_init = 1'b1;
        end else begin
            lands = mt && !ev && !it && !er;
            m_ip7 = (lands && a == 5'd11) ? 1'b0 : (m_ip7 | (m_count == m_compare));
            m_count = (lands && a == 5'd9) ? wd : m_count + 1;
            if (lands && a == 5'd11) m_compare = wd;
            m_cause = (m_cause & ~32'h0000FC00) | (32'(cur_irq) << 10);
            if (ev) begin
                if (!m_status[1]) m_epc = pcv;
                m_cause = (m_cause & ~32'h7C) | (32'(ec) << 2);
                m_status = m_status | 32'h2;
            end else if (it) begin
                m_epc = pcv;
                m_cause = m_cause & ~32'h7C;
                m_status = m_status | 32'h2;
            end else if (er) begin
                m_status = m_status & ~32'h2;
            end else if (mt) begin
                case (a)
                    5'd12: m_status = wd & 32'h0000FF03;
                    5'd13: m_cause = (m_cause & ~32'h300) | (wd & 32'h300);
                    5'd14: m_epc = wd;
                    default: ;
                endcase
            end
        end
    endtask

    task automatic idle();   cyc(0, 0, 0, 5'd0, 32'h0, $urandom, 0, 5'd0, 0); endtask
    task automatic rd(input logic [4:0] a); cyc(0, 1, 0, a, 32'h0, $urandom, 0, 5'd0, 0); endtask
    task automatic wr(input logic [4:0] a, input logic [31:0] d); cyc(0, 0, 1, a, d, $urandom, 0, 5'd0, 0); endtask

    // Monitor: compares every presented cycle against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("redirect", {31'b0, redirect}, {31'b0, e.redirect});
                chk("redirect_pc", redirect_pc, e.rpc);
                chk("rdata", rdata, e.rdata);
                if (e.chk_status) chk("status", status, e.status);
            end
        end
    end

    initial begin
        logic [4:0] alist [6];
        logic [4:0] a;
        // reset and reset values
        cyc(1, 1, 0, 5'd12, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 5'd0, 0, 0, 0, 0, 0);
        rd(5'd12); rd(5'd13); rd(5'd14);
        // syscall
        cyc(0, 0, 0, 5'd0, 0, 32'h00400100, 1, 5'd8, 0);
        rd(5'd14); rd(5'd13); rd(5'd12);
        // eret
        cyc(0, 0, 0, 5'd0, 0, 32'h00400200, 0, 5'd0, 1);
        rd(5'd12);
        // interrupt masking, then enabling
        wr(5'd12, 32'h00000001);
        cur_irq = 6'h01;
        idle(); rd(5'd13);
        wr(5'd12, 32'h00000401);
        idle(); rd(5'd13); rd(5'd14);
        // exception in the same cycle as a pending interrupt
        cyc(0, 0, 0, 5'd0, 0, 32'h00400300, 0, 5'd0, 1);
        cyc(0, 0, 0, 5'd0, 0, 32'h00400400, 1, 5'd12, 0);
        rd(5'd13);
        // nested exception, mtc0 in the exception cycle is dropped
        cyc(0, 0, 1, 5'd14, 32'hDEADBEEF, 32'h00000200, 1, 5'd10, 0);
        rd(5'd14); rd(5'd13);
        cyc(0, 0, 0, 5'd0, 0, 32'h0, 0, 5'd0, 1);
        cur_irq = 6'h00;
        wr(5'd12, 32'h0000FF01);
        // same-cycle read and write return the old value
        cyc(0, 1, 1, 5'd14, 32'h12345678, 32'h0, 0, 5'd0, 0);
        rd(5'd14);
        wr(5'd13, 32'hFFFFFFFF); rd(5'd13);
        wr(5'd13, 32'h0);
`ifdef CP0_TIMER_EN
        wr(5'd12, 32'h0);
        wr(5'd9, 32'h0); wr(5'd11, 32'h5);
        for (int i = 0; i < 8; i++) rd(5'd13);
        wr(5'd11, 32'h100); rd(5'd13);
        wr(5'd9, 32'hFFFFFFFF); rd(5'd9); rd(5'd9);
        wr(5'd12, 32'h0000FF01);
`endif
        // randomized traffic
        alist[0] = 5'd9; alist[1] = 5'd11; alist[2] = 5'd12;
        alist[3] = 5'd13; alist[4] = 5'd14; alist[5] = 5'd0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) == 0) cur_irq = 6'($urandom);
            a = ($urandom_range(0, 5) == 5) ? 5'($urandom) : alist[$urandom_range(0, 4)];
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 3) == 0, a, $urandom, $urandom,
                $urandom_range(0, 9) == 0, 5'($urandom), $urandom_range(0, 9) == 0);
        end
        @(negedge clk);
        #5;
        chk("queue_drained", 32'(q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
